// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the OV7670 SCCB boot loader.
//   - sccb_entry_t : one register-table entry {addr, data}
//   - sccb_state_t : loader FSM states
//   - ADDR_DELAY   : table address value that marks "wait" instead of a write
//   - NUM_REGS     : number of table entries (index NUM_REGS means exhausted)
//   - tail_entry() : the part of the table that follows the fixed head
package sccb_pkg;

    localparam logic [7:0] ADDR_DELAY = 8'hFF;
    localparam int         NUM_REGS   = 6;
    localparam int         FRAME_BITS = 27;

    // OV7670 register addresses used by the table
    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_CLKRC  = 8'h11;
    localparam logic [7:0] REG_TSLB   = 8'h3A;
    localparam logic [7:0] REG_COM15  = 8'h40;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sccb_entry_t;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
    } sccb_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Entries after the fixed head (0..2 live in the ROM itself).
    function automatic sccb_entry_t tail_entry(input logic [7:0] idx);
        case (idx)
            8'd3:    return {REG_CLKRC, 8'h01};  // PLL bypass, prescale /2
            8'd4:    return {REG_TSLB,  8'h04};  // UYVY byte order
            8'd5:    return {REG_COM15, 8'hD0};  // full 00..FF output range
            default: return {8'h00, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/sccb_config_if.sv
// sccb_config_if: SCCB pin-side bundle of the boot loader.
//   start    : one-cycle rerun request (ignored while busy)
//   sioc     : SCCB clock, push-pull
//   siod_out : SCCB data value (always 0; the line is only ever pulled low)
//   siod_oe  : 1 = drive siod_out, 0 = release to the pull-up
//   busy     : sequence in progress
//   done     : table fully written (sticky)
//   index    : current table entry, debug only
interface sccb_config_if;
    logic       start;
    logic       sioc;
    logic       siod_out;
    logic       siod_oe;
    logic       busy;
    logic       done;
    logic [7:0] index;

    modport master (input start, output sioc, siod_out, siod_oe, busy, done, index);
    modport slave  (output start, input sioc, siod_out, siod_oe, busy, done, index);
endinterface

// File: rtl/sccb_config_rom.sv
// sccb_config_rom: combinational register table.
//   index : entry number
//   entry : {addr, data}; addr == ADDR_DELAY marks a delay entry
module sccb_config_rom
    import sccb_pkg::*;
(
    input  logic [7:0]  index,
    output sccb_entry_t entry
);
    always_comb begin
        case (index)
            8'd0:    entry = {REG_COM7, 8'h80};    // soft reset
            8'd1:    entry = {ADDR_DELAY, 8'h00};  // let the reset settle
            8'd2:    entry = {REG_COM7, 8'h00};    // YUV output
            default: entry = tail_entry(index);
        endcase
    end
endmodule

// File: rtl/sccb_config.sv
// sccb_config: boot-time OV7670 register loader over SCCB (write-only).
// After reset (or start while idle) it waits PWR_WAIT cycles, then issues
// one 3-phase write {DEV_ID, addr, data} per table entry, with GAP idle
// cycles between frames and DELAY_CYCLES for delay-marker entries.
//   CLOCK_24 : system clock (rising edge)
//   RESET    : asynchronous active-high reset
//   bus      : sccb_config_if master modport (pins + status)
module sccb_config
    import sccb_pkg::*;
#(
    parameter int         QUARTER      = 60,
    parameter int         PWR_WAIT     = 24000,
    parameter int         DELAY_CYCLES = 24000,
    parameter int         GAP          = 240,
    parameter logic [7:0] DEV_ID       = 8'h42
) (
    input  logic          CLOCK_24,
    input  logic          RESET,
    sccb_config_if.master bus
);
    localparam int QW       = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int WAIT_MAX = max3(PWR_WAIT, DELAY_CYCLES, GAP);
    localparam int WW       = $clog2(WAIT_MAX + 1);

    localparam logic [QW-1:0] Q_LAST     = QW'(QUARTER - 1);
    localparam logic [WW-1:0] PWR_LAST   = WW'(PWR_WAIT - 1);
    localparam logic [WW-1:0] DELAY_LAST = WW'(DELAY_CYCLES - 1);
    localparam logic [WW-1:0] GAP_LAST   = WW'(GAP - 1);

    sccb_state_t           state_q, state_d;
    logic [QW-1:0]         qcnt_q, qcnt_d;    // cycles within a quarter
    logic [1:0]            phase_q, phase_d;  // quarter within START/bit/STOP
    logic [4:0]            bit_q, bit_d;      // frame bit number
    logic [WW-1:0]         wait_q, wait_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [7:0]            index_q, index_d;
    logic                  busy_q, busy_d;

    sccb_entry_t entry;
    logic        q_tick;
    logic        sioc_o, siod_oe_o;

    sccb_config_rom u_rom (.index(index_q), .entry(entry));

    assign q_tick = (qcnt_q == Q_LAST);

    // State register
    always_ff @(posedge CLOCK_24 or posedge RESET) begin
        if (RESET) begin
            state_q <= S_PWR;
            qcnt_q  <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            shift_q <= '1;
            index_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            shift_q <= shift_d;
            index_q <= index_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        shift_d = shift_q;
        index_d = index_q;
        unique case (state_q)
            S_PWR: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == PWR_LAST) begin
                    wait_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                qcnt_d  = '0;
                phase_d = '0;
                bit_d   = '0;
                wait_d  = '0;
                if (index_q == 8'(NUM_REGS)) begin
                    state_d = S_DONE;
                end else if (entry.addr == ADDR_DELAY) begin
                    state_d = S_DELAY;
                end else begin
                    // 1s in the don't-care slots release SIOD for the ACKs
                    shift_d = {DEV_ID, 1'b1, entry.addr, 1'b1, entry.data, 1'b1};
                    state_d = S_START;
                end
            end
            S_START: begin
                qcnt_d = q_tick ? '0 : qcnt_q + 1'b1;
                if (q_tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd1) begin
                        phase_d = '0;
                        state_d = S_BITS;
                    end
                end
            end
            S_BITS: begin
                qcnt_d = q_tick ? '0 : qcnt_q + 1'b1;
                if (q_tick) begin
                    phase_d = phase_q + 2'd1;  // wraps 3 -> 0
                    if (phase_q == 2'd3) begin
                        // shifting at the end of q3 makes SIOD change at q0
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b1};
                        bit_d   = bit_q + 5'd1;
                        if (bit_q == 5'(FRAME_BITS - 1))
                            state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                qcnt_d = q_tick ? '0 : qcnt_q + 1'b1;
                if (q_tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2) begin
                        phase_d = '0;
                        wait_d  = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == GAP_LAST) begin
                    index_d = index_q + 8'd1;
                    state_d = S_LOAD;
                end
            end
            S_DELAY: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == DELAY_LAST) begin
                    index_d = index_q + 8'd1;
                    state_d = S_LOAD;
                end
            end
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    index_d = '0;
                    wait_d  = '0;
                    state_d = S_PWR;
                end
            end
            default: state_d = S_PWR;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // Output decode; bus idle (SIOC high, SIOD released) unless framing
    always_comb begin
        sioc_o    = 1'b1;
        siod_oe_o = 1'b0;
        case (state_q)
            S_START: siod_oe_o = 1'b1;
            S_BITS: begin
                sioc_o    = phase_q[1];
                siod_oe_o = ~shift_q[FRAME_BITS-1];
            end
            S_STOP: begin
                sioc_o    = (phase_q != 2'd0);
                siod_oe_o = (phase_q != 2'd2);
            end
            default: ;
        endcase
    end

    assign bus.sioc     = sioc_o;
    assign bus.siod_oe  = siod_oe_o;
    assign bus.siod_out = 1'b0;
    assign bus.busy     = busy_q;
    assign bus.done     = (state_q == S_DONE);
    assign bus.index    = index_q;

endmodule

// File: tb/tb_sccb_config.sv
`timescale 1ns/1ps
// tb_sccb_config: decodes the SCCB pins into frames and compares them with a
// model derived from the register table and the frame/gap/delay timing.
module tb_sccb_config;
    localparam int Q  = 2;
    localparam int PW = 10;
    localparam int DC = 20;
    localparam int GP = 8;
    localparam int NREG = 6;
    localparam int FRAME_CYC = 113 * Q;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sccb_config_if bus();

    sccb_config #(.QUARTER(Q), .PWR_WAIT(PW), .DELAY_CYCLES(DC), .GAP(GP), .DEV_ID(8'h42))
        dut (.CLOCK_24(clk), .RESET(rst), .bus(bus));

    always #5 clk = ~clk;

    // Expected register table {addr, data}
    logic [15:0] tbl [NREG] = '{16'h1280, 16'hFF00, 16'h1200, 16'h1101, 16'h3A04, 16'h40D0};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SCCB monitor ----------------
    typedef struct {
        logic [26:0] bits;
        int          nb;
        int          cyc;
        int          idx;
    } frame_t;

    frame_t      frames[$];
    int          cyc = 0;
    int          viol_out = 0;
    int          viol_toggle = 0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        sda;
    logic        in_frame = 1'b0;
    logic [27:0] sh;
    int          nb;
    int          start_cyc;
    int          start_idx;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        sda = bus.siod_oe ? bus.siod_out : 1'b1;
        if (bus.siod_oe && bus.siod_out) viol_out++;
        if (rst) begin
            in_frame = 1'b0;
        end else if (prev_scl && bus.sioc && (sda != prev_sda)) begin
            if (!sda && !in_frame) begin
                in_frame  = 1'b1;
                sh        = '0;
                nb        = 0;
                start_cyc = cyc;
                start_idx = int'(bus.index);
            end else if (sda && in_frame) begin
                in_frame = 1'b0;
                frames.push_back('{sh[27:1], nb, start_cyc, start_idx});
                $display("frame idx=%0d id=%02h addr=%02h data=%02h bits=%0d start_cycle=%0d",
                         start_idx, sh[27:20], sh[18:11], sh[9:2], nb, start_cyc);
            end else begin
                viol_toggle++;
            end
        end else if (in_frame && !prev_scl && bus.sioc) begin
            sh = {sh[26:0], sda};
            nb++;
        end
        prev_scl = bus.sioc;
        prev_sda = sda;
    end

    // ---------------- reference model ----------------
    // Walks the table: a write frame per non-delay entry; each frame starts
    // PW+1 cycles after the run begins, then every 113Q+GAP+LOAD cycles,
    // with DELAY+LOAD cycles extra for each delay marker passed.
    task automatic check_run(input string tag, input int ref_cyc, input int base);
        int exp_cyc;
        int k;
        int n_exp;
        frame_t f;
        exp_cyc = ref_cyc + PW + 1;
        k = 0;
        n_exp = 0;
        for (int i = 0; i < NREG; i++)
            if (tbl[i][15:8] != 8'hFF) n_exp++;
        check_val({tag, "_frame_count"}, frames.size() - base, n_exp);
        for (int i = 0; i < NREG; i++) begin
            if (tbl[i][15:8] == 8'hFF) begin
                exp_cyc += DC + 1;
            end else begin
                if (base + k < frames.size()) begin
                    f = frames[base + k];
                    check_val($sformatf("%s_e%0d_nbits", tag, i), f.nb, 28);
                    check_val($sformatf("%s_e%0d_id", tag, i), f.bits[26:19], 8'h42);
                    check_val($sformatf("%s_e%0d_zbits", tag, i), {f.bits[18], f.bits[9], f.bits[0]}, 3'b111);
                    check_val($sformatf("%s_e%0d_addr", tag, i), f.bits[17:10], tbl[i][15:8]);
                    check_val($sformatf("%s_e%0d_data", tag, i), f.bits[8:1], tbl[i][7:0]);
                    check_val($sformatf("%s_e%0d_index", tag, i), f.idx, i);
                    check_val($sformatf("%s_e%0d_start_cycle", tag, i), f.cyc, exp_cyc);
                end
                exp_cyc += FRAME_CYC + GP + 1;
                k++;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done_reached"}, bus.done, 1);
        check_val({tag, "_busy_at_done"}, bus.busy, 0);
        check_val({tag, "_index_at_done"}, bus.index, NREG);
        check_val({tag, "_bus_idle_at_done"}, {bus.sioc, bus.siod_oe}, 2'b10);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int ref_a, ref_b, ref_c, base, n;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outputs", {bus.sioc, bus.siod_oe, bus.siod_out, bus.busy, bus.done}, 5'b10000);
        check_val("rst_index", bus.index, 0);

        // --- run A: power-up wait, ignored start pulses ---
        base  = frames.size();
        ref_a = cyc;
        rst   = 1'b0;
        for (int k = 1; k <= PW; k++) begin
            @(posedge clk); #1;
            check_val("pwr_idle", {bus.sioc, bus.siod_oe, bus.done, bus.index}, {3'b100, 8'd0});
        end
        @(posedge clk); #1;
        check_val("first_siod_low", {bus.sioc, bus.siod_oe}, 2'b11);
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(20, 300)) @(posedge clk);
            #1;
            check_val("busy_before_start", bus.busy, 1);
            pulse_start();
        end
        wait_done("runA");
        check_run("runA", ref_a, base);

        // --- run B: done is sticky, start reruns the same sequence ---
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #1;
        check_val("done_sticky", bus.done, 1);
        base = frames.size();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        ref_b = cyc;
        bus.start = 1'b0;
        check_val("start_clears", {bus.done, bus.busy, bus.index}, {2'b01, 8'd0});
        wait_done("runB");
        check_run("runB", ref_b, base);

        // --- run C: reset during BITS of entry 2, restart from entry 0 ---
        pulse_start();
        n = 0;
        while (!(bus.index == 8'd2 && bus.siod_oe) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_entry2", bus.index, 2);
        repeat ($urandom_range(4, 200)) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("async_rst_bus", {bus.sioc, bus.siod_oe, bus.busy, bus.index}, {3'b100, 8'd0});
        repeat ($urandom_range(2, 5)) @(posedge clk);
        #1;
        base  = frames.size();
        ref_c = cyc;
        rst   = 1'b0;
        wait_done("runC");
        check_run("runC", ref_c, base);

        check_val("siod_out_driven_high", viol_out, 0);
        check_val("siod_toggle_while_sioc_high", viol_toggle, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
